// File: rtl/counter_game_pkg.sv
// -----------------------------------------------------------------------------
// counter_game_pkg
//   Shared types for the counter_game block:
//     mode_e       - count step selected by the 2-bit ctrl input
//     result_e     - game result reported on the who output
//     game_state_e - states of the game-over FSM
//   Helper functions decode a mode into step direction and step size.
// -----------------------------------------------------------------------------
package counter_game_pkg;

    localparam int unsigned DEFAULT_N = 4;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        WIN  = 2'b10,
        LOSE = 2'b01
    } result_e;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } game_state_e;

    // The mode encoding is chosen so bit 1 is the direction and bit 0 the size.
    function automatic logic mode_is_down(input mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_is_two(input mode_e m);
        return m[0];
    endfunction

endpackage

// File: rtl/counter_game_updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//   Loadable up/down N-bit counter with registered landing pulses.
//   Ports:
//     i_clk     - rising-edge clock
//     i_rst     - asynchronous active-high reset
//     i_mode    - step mode (up/down by 1 or 2), applied every edge
//     i_init    - synchronous load enable
//     i_val     - load value
//     i_clear   - forces the next count to zero, highest priority
//     o_cnt     - current count
//     o_winner  - one-cycle pulse: count just landed on all-ones
//     o_loser   - one-cycle pulse: count just landed on zero
// -----------------------------------------------------------------------------
module updown_counter
    import counter_game_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  mode_e        i_mode,
    input  logic         i_init,
    input  logic [N-1:0] i_val,
    input  logic         i_clear,
    output logic [N-1:0] o_cnt,
    output logic         o_winner,
    output logic         o_loser
);

    localparam logic [N-1:0] ALL_ONES = '1;

    logic [N-1:0] r_cnt;
    logic         r_winner;
    logic         r_loser;

    logic [N-1:0] w_step;
    logic [N-1:0] w_stepped;
    logic [N-1:0] w_next;

    // N-bit arithmetic wraps modulo 2^N in both directions for free.
    assign w_step    = mode_is_two(i_mode) ? N'(2) : N'(1);
    assign w_stepped = mode_is_down(i_mode) ? (r_cnt - w_step) : (r_cnt + w_step);

    // Priority: clear, then load, then step.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next (no latch).
        w_next = w_stepped;
        if (i_clear) begin
            w_next = '0;
        end else if (i_init) begin
            w_next = i_val;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_winner <= 1'b0;
            r_loser  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers sample pre-edge values.
            r_cnt    <= w_next;
            // Pulses flag where the count lands, not values skipped by a step
            // of two; the forced clear after game over is not a landing.
            r_winner <= !i_clear && (w_next == ALL_ONES);
            r_loser  <= !i_clear && (w_next == '0);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_winner = r_winner;
    assign o_loser  = r_loser;

endmodule

// File: rtl/counter_game.sv
// -----------------------------------------------------------------------------
// counter_game
//   Up/down loadable counter with a scoring game on top. Each winner pulse
//   (count landed on all-ones) or loser pulse (count landed on zero) bumps
//   its tally; the first tally to reach 2^N-1 ends the game, reports the side
//   on who, and clears the counter and both tallies.
//   Ports:
//     clk      - rising-edge clock
//     rst      - asynchronous active-high reset
//     ctrl     - count mode: 00 +1, 01 +2, 10 -1, 11 -2
//     init     - synchronous load enable
//     val      - load value
//     cnt      - current count
//     winner   - one-cycle pulse, count just became 2^N-1
//     loser    - one-cycle pulse, count just became 0
//     gameover - one-cycle pulse, game finished
//     who      - last result: 00 none, 10 winner side, 01 loser side
// -----------------------------------------------------------------------------
module counter_game
    import counter_game_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ctrl,
    input  logic         init,
    input  logic [N-1:0] val,
    output logic [N-1:0] cnt,
    output logic         winner,
    output logic         loser,
    output logic         gameover,
    output logic [1:0]   who
);

    localparam logic [N-1:0] ALL_ONES   = '1;
    // A pulse seen while the tally holds this value is the one that reaches
    // 2^N-1 and ends the game.
    localparam logic [N-1:0] TALLY_LAST = ALL_ONES - N'(1);

    game_state_e  r_state;
    game_state_e  w_state_next;
    logic [N-1:0] r_win_tally;
    logic [N-1:0] r_lose_tally;
    logic [N-1:0] w_win_tally_next;
    logic [N-1:0] w_lose_tally_next;
    result_e      r_who;
    result_e      w_who_next;

    logic         w_clear;
    logic         w_winner;
    logic         w_loser;

    // The OVER cycle is the cycle gameover is high; the counter clears at
    // the edge that ends it.
    assign w_clear = (r_state == OVER);

    updown_counter #(
        .N (N)
    ) u_counter (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_mode   (mode_e'(ctrl)),
        .i_init   (init),
        .i_val    (val),
        .i_clear  (w_clear),
        .o_cnt    (cnt),
        .o_winner (w_winner),
        .o_loser  (w_loser)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PLAY;
            r_win_tally  <= '0;
            r_lose_tally <= '0;
            r_who        <= NONE;
        end else begin
            r_state      <= w_state_next;
            r_win_tally  <= w_win_tally_next;
            r_lose_tally <= w_lose_tally_next;
            r_who        <= w_who_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_win_tally_next  = r_win_tally;
        w_lose_tally_next = r_lose_tally;
        w_who_next        = r_who;

        unique case (r_state)
            PLAY: begin
                // winner and loser are mutually exclusive, so no tie exists.
                if (w_winner) begin
                    if (r_win_tally == TALLY_LAST) begin
                        w_state_next      = OVER;
                        w_who_next        = WIN;
                        w_win_tally_next  = '0;
                        w_lose_tally_next = '0;
                    end else begin
                        w_win_tally_next = r_win_tally + N'(1);
                    end
                end else if (w_loser) begin
                    if (r_lose_tally == TALLY_LAST) begin
                        w_state_next      = OVER;
                        w_who_next        = LOSE;
                        w_win_tally_next  = '0;
                        w_lose_tally_next = '0;
                    end else begin
                        w_lose_tally_next = r_lose_tally + N'(1);
                    end
                end
            end
            OVER: begin
                // Tallies stay cleared through the game-over cycle so the new
                // game starts from zero.
                w_state_next      = PLAY;
                w_win_tally_next  = '0;
                w_lose_tally_next = '0;
            end
            default: begin
                w_state_next = PLAY;
            end
        endcase
    end

    assign winner   = w_winner;
    assign loser    = w_loser;
    assign gameover = (r_state == OVER);
    assign who      = r_who;

endmodule

// File: tb/tb_counter_game.sv
// -----------------------------------------------------------------------------
// tb_counter_game
//   Directed self-checking bench for counter_game (N=4). A table of
//   {inputs, expected outputs} covers stepping, wrap-around and load priority;
//   hand-written sequences cover the win/lose games, forced clear and the
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_counter_game;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   ctrl;
    logic         init;
    logic [N-1:0] val;
    logic [N-1:0] cnt;
    logic         winner;
    logic         loser;
    logic         gameover;
    logic [1:0]   who;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]   ctrl;
        logic         init;
        logic [N-1:0] val;
        logic [N-1:0] cnt;
        logic         w;
        logic         l;
    } vec_t;

    vec_t vecs[$];

    counter_game #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .init     (init),
        .val      (val),
        .cnt      (cnt),
        .winner   (winner),
        .loser    (loser),
        .gameover (gameover),
        .who      (who)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    function automatic void add(input logic [1:0] c, input logic i, input logic [N-1:0] v,
                                input logic [N-1:0] e_cnt, input logic e_w, input logic e_l);
        vec_t r;
        r.ctrl = c; r.init = i; r.val = v; r.cnt = e_cnt; r.w = e_w; r.l = e_l;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [N-1:0] e_cnt, input logic e_w,
                         input logic e_l, input logic e_go, input logic [1:0] e_who);
        n_vec++;
        if (cnt !== e_cnt || winner !== e_w || loser !== e_l || gameover !== e_go || who !== e_who) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d winner=%b loser=%b gameover=%b who=%b, want cnt=%0d winner=%b loser=%b gameover=%b who=%b",
                     name, cnt, winner, loser, gameover, who, e_cnt, e_w, e_l, e_go, e_who);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic [1:0] c, input logic i, input logic [N-1:0] v);
        ctrl = c;
        init = i;
        val  = v;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted across one rising edge, checked while asserted.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_held", 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        ctrl = 2'b00;
        init = 1'b0;
        val  = '0;
        #2;
        check("reset_state", 0, 0, 0, 0, 2'b00);
        #10;
        rst = 1'b0;

        // down-by-2 from 0: 14,12,...,2,0 (loser), then wrap to 14
        add(2'b11, 0, 0, 14, 0, 0);
        add(2'b11, 0, 0, 12, 0, 0);
        add(2'b11, 0, 0, 10, 0, 0);
        add(2'b11, 0, 0,  8, 0, 0);
        add(2'b11, 0, 0,  6, 0, 0);
        add(2'b11, 0, 0,  4, 0, 0);
        add(2'b11, 0, 0,  2, 0, 0);
        add(2'b11, 0, 0,  0, 0, 1);
        add(2'b11, 0, 0, 14, 0, 0);
        // load beats ctrl; down-by-1 wraps 0 -> 15
        add(2'b11, 1, 0,  0, 0, 1);
        add(2'b10, 0, 0, 15, 1, 0);
        add(2'b10, 0, 0, 14, 0, 0);
        add(2'b10, 1, 2,  2, 0, 0);
        add(2'b10, 0, 0,  1, 0, 0);
        add(2'b10, 0, 0,  0, 0, 1);
        add(2'b10, 0, 0, 15, 1, 0);
        // up-by-2: 13 -> 15 (winner) -> 1; 14 -> 0 (loser, 15 skipped) -> 2
        add(2'b01, 1, 13, 13, 0, 0);
        add(2'b01, 0, 0, 15, 1, 0);
        add(2'b01, 0, 0,  1, 0, 0);
        add(2'b01, 1, 14, 14, 0, 0);
        add(2'b01, 0, 0,  0, 0, 1);
        add(2'b01, 0, 0,  2, 0, 0);
        // up-by-1 wrap 15 -> 0
        add(2'b00, 1, 15, 15, 1, 0);
        add(2'b00, 0, 0,  0, 0, 1);
        add(2'b00, 0, 0,  1, 0, 0);
        // ctrl changing every cycle: 1 -2 -> 15, +1 -> 0, +2 -> 2, -2 -> 0, -2 -> 14
        add(2'b11, 0, 0, 15, 1, 0);
        add(2'b00, 0, 0,  0, 0, 1);
        add(2'b01, 0, 0,  2, 0, 0);
        add(2'b11, 0, 0,  0, 0, 1);
        add(2'b11, 0, 0, 14, 0, 0);
        // init held: reload of 15 pulses winner every cycle
        add(2'b00, 1, 15, 15, 1, 0);
        add(2'b00, 1, 15, 15, 1, 0);
        add(2'b00, 1, 15, 15, 1, 0);
        add(2'b00, 0, 0,  0, 0, 1);

        foreach (vecs[k]) begin
            step(vecs[k].ctrl, vecs[k].init, vecs[k].val);
            check($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].w, vecs[k].l, 1'b0, 2'b00);
        end

        // Winner game: 15 winner pulses end the game on the following edge.
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            step(2'b00, 1, 14);
            check($sformatf("win_load%0d", i), 14, 0, 0, 0, 2'b00);
            step(2'b00, 0, 0);
            check($sformatf("win_land%0d", i), 15, 1, 0, 0, 2'b00);
        end
        step(2'b00, 1, 14);
        check("win_gameover", 14, 0, 0, 1, 2'b10);
        // clear outranks the load of 5
        step(2'b00, 1, 5);
        check("win_clear", 0, 0, 0, 0, 2'b10);

        // Tallies restarted from zero: 14 winners do not end the game, 15 do.
        for (int i = 0; i < 14; i++) begin
            step(2'b00, 1, 14);
            check($sformatf("g2_load%0d", i), 14, 0, 0, 0, 2'b10);
            step(2'b00, 0, 0);
            check($sformatf("g2_land%0d", i), 15, 1, 0, 0, 2'b10);
        end
        step(2'b00, 1, 14);
        check("g2_14_no_over", 14, 0, 0, 0, 2'b10);
        step(2'b00, 0, 0);
        check("g2_land15", 15, 1, 0, 0, 2'b10);
        step(2'b00, 1, 14);
        check("g2_gameover", 14, 0, 0, 1, 2'b10);
        // step from 14 would land on 15; clear wins and no winner pulses
        step(2'b00, 0, 0);
        check("g2_clear", 0, 0, 0, 0, 2'b10);

        // Loser game: who keeps 10 until the loser side ends a game.
        for (int i = 0; i < 15; i++) begin
            step(2'b10, 1, 1);
            check($sformatf("lose_load%0d", i), 1, 0, 0, 0, 2'b10);
            step(2'b10, 0, 0);
            check($sformatf("lose_land%0d", i), 0, 0, 1, 0, 2'b10);
        end
        step(2'b10, 1, 1);
        check("lose_gameover", 1, 0, 0, 1, 2'b01);
        // down-1 from 1 would land on 0; the clear must not pulse loser
        step(2'b10, 0, 0);
        check("lose_clear", 0, 0, 0, 0, 2'b01);

        // Asynchronous reset between edges clears everything at once.
        step(2'b00, 1, 9);
        check("pre_rst_9", 9, 0, 0, 0, 2'b01);
        step(2'b00, 1, 15);
        check("pre_rst_15", 15, 1, 0, 0, 2'b01);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 0, 0, 0, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check("rst_release", 0, 0, 0, 0, 2'b00);
        step(2'b00, 0, 0);
        check("resume1", 1, 0, 0, 0, 2'b00);
        step(2'b00, 0, 0);
        check("resume2", 2, 0, 0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
